// File: rtl/slow_path_arbiter_pkg.sv
// Shared types for the slow/fast path arbiter: FSM state encoding, path-select
// values and a small sizing helper.
package slow_path_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_A  = 2'd1,
      OWN_B  = 2'd2,
      SWITCH = 2'd3
   } state_e;

   localparam logic SEL_FAST = 1'b0;
   localparam logic SEL_SLOW = 1'b1;

   // Larger of two parameters, used to size the shared counters.
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/slow_path_arbiter_if.sv
// Handshake bundle between the two requesters, the sink and the arbiter.
// master = requester/sink side, slave = arbiter.
interface slow_path_arbiter_if #(
   parameter int W = 8
);
   logic         a_valid;
   logic [W-1:0] a_data;
   logic         a_ready;
   logic         b_valid;
   logic [W-1:0] b_data;
   logic         b_ready;
   logic         slow;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         busy;

   modport master (
      output a_valid, a_data, b_valid, b_data,
      input  a_ready, b_ready, slow, out_valid, out_data, busy
   );

   modport slave (
      input  a_valid, a_data, b_valid, b_data,
      output a_ready, b_ready, slow, out_valid, out_data, busy
   );
endinterface

// File: rtl/slow_path_arbiter_dwell_burst_cnt.sv
// Ownership dwell (saturating) and burst counters. Both clear while the path
// is not owned; the burst counter can also be cleared by the owner to restart
// a burst when nobody else is waiting.
module dwell_burst_cnt
   import slow_path_pkg::*;
#(
   parameter int DWELL     = 4,
   parameter int MAX_BURST = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic dwell_inc_i,
   input  logic burst_inc_i,
   input  logic burst_clr_i,
   output logic dwell_done_o,
   output logic burst_done_o
);
   localparam int CW = $clog2(max2(DWELL, MAX_BURST) + 1);
   localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL);
   localparam logic [CW-1:0] DWELL_M1  = CW'(DWELL - 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

   logic [CW-1:0] dwell_q, dwell_d;
   logic [CW-1:0] burst_q, burst_d;

   // Next-state: dwell saturates at DWELL, burst never wraps (cleared explicitly).
   always_comb begin
      dwell_d = dwell_q;
      burst_d = burst_q;
      if (clr_i) begin
         dwell_d = '0;
         burst_d = '0;
      end else begin
         if (dwell_inc_i && (dwell_q != DWELL_MAX)) dwell_d = dwell_q + 1'b1;
         if (burst_clr_i)      burst_d = '0;
         else if (burst_inc_i) burst_d = burst_q + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell_q <= '0;
         burst_q <= '0;
      end else begin
         dwell_q <= dwell_d;
         burst_q <= burst_d;
      end
   end

   assign dwell_done_o = (dwell_q >= DWELL_M1);
   assign burst_done_o = (burst_q == BURST_MAX);

endmodule

// File: rtl/slow_path_arbiter.sv
// Owns the fast/slow path select of the dual-path datapath. Arbitrates
// requester A (fast) and B (slow) into one sink register with a minimum
// dwell, bounded bursts and a dead SWITCH cycle between owners.
module slow_path_arbiter
   import slow_path_pkg::*;
#(
   parameter int W         = 8,
   parameter int DWELL     = 4,
   parameter int MAX_BURST = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   slow_path_arbiter_if.slave bus
);
   state_e       state_q;
   logic         slow_q;
   logic         out_valid_q;
   logic [W-1:0] out_data_q;

   logic own_a, own_b, owning;
   logic dwell_done, burst_done;
   logic a_ready, b_ready;
   logic accept_a, accept_b;
   logic own_valid, other_valid;
   logic idle_tgt;

   assign own_a  = (state_q == OWN_A);
   assign own_b  = (state_q == OWN_B);
   assign owning = own_a || own_b;

   // Ready is a pure function of registered state: low on the burst-limit cycle.
   assign a_ready  = own_a && !burst_done;
   assign b_ready  = own_b && !burst_done;
   assign accept_a = a_ready && bus.a_valid;
   assign accept_b = b_ready && bus.b_valid;

   assign own_valid   = own_b ? bus.b_valid : bus.a_valid;
   assign other_valid = own_b ? bus.a_valid : bus.b_valid;

   // On a tie the path not currently selected wins, so neither side starves.
   assign idle_tgt = (bus.a_valid && bus.b_valid) ? ~slow_q
                   : (bus.a_valid ? SEL_FAST : SEL_SLOW);

   dwell_burst_cnt #(
      .DWELL     (DWELL),
      .MAX_BURST (MAX_BURST)
   ) u_cnt (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (!owning),
      .dwell_inc_i  (owning),
      .burst_inc_i  (accept_a || accept_b),
      .burst_clr_i  (owning && burst_done && !other_valid),
      .dwell_done_o (dwell_done),
      .burst_done_o (burst_done)
   );

   // Ownership FSM; slow only flips on the SWITCH -> OWN edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         slow_q  <= SEL_FAST;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.a_valid || bus.b_valid) begin
                  if (idle_tgt == slow_q) state_q <= idle_tgt ? OWN_B : OWN_A;
                  else                    state_q <= SWITCH;
               end
            end
            OWN_A, OWN_B: begin
               if (other_valid && dwell_done && (!own_valid || burst_done))
                  state_q <= SWITCH;
               else if (!bus.a_valid && !bus.b_valid && dwell_done)
                  state_q <= IDLE;
            end
            SWITCH: begin
               state_q <= slow_q ? OWN_A : OWN_B;
               slow_q  <= ~slow_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Sink register: captures the winner's word, out_valid pulses for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= accept_a || accept_b;
         if (accept_a)      out_data_q <= bus.a_data;
         else if (accept_b) out_data_q <= bus.b_data;
      end
   end

   assign bus.a_ready   = a_ready;
   assign bus.b_ready   = b_ready;
   assign bus.slow      = slow_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_slow_path_arbiter.sv
// Directed bench for slow_path_arbiter with DWELL=2, MAX_BURST=3, W=8.
module tb_slow_path_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   slow_path_arbiter_if #(.W(8)) bus ();

   slow_path_arbiter #(
      .W         (8),
      .DWELL     (2),
      .MAX_BURST (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bit         exp_rdy [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      int         idx;
      logic       prev_acc;
      logic [7:0] last;

      // 1. reset with random valids
      bus.a_valid = 1'($urandom_range(0, 1));
      bus.b_valid = 1'($urandom_range(0, 1));
      bus.a_data  = 8'($urandom);
      bus.b_data  = 8'($urandom);
      tick(); tick();
      bus.a_valid = 1'($urandom_range(0, 1));
      bus.b_valid = 1'($urandom_range(0, 1));
      tick();
      chk("rst_slow", bus.slow, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_readies", {bus.a_ready, bus.b_ready}, 0);

      rst_n = 1'b1;
      bus.a_valid = 1'b1; bus.a_data = 8'h11; bus.b_valid = 1'b0;
      tick();
      chk("s1_busy", bus.busy, 1);
      chk("s1_a_ready", bus.a_ready, 1);
      chk("s1_slow", bus.slow, 0);
      chk("s1_ov_lat", bus.out_valid, 0);
      tick();
      bus.a_valid = 1'b0;
      chk("s1_ov", bus.out_valid, 1);
      chk("s1_od", bus.out_data, 8'h11);
      tick();
      chk("s1_idle", bus.busy, 0);
      chk("s1_ov_pulse", bus.out_valid, 0);

      // 2. B only from IDLE
      bus.b_valid = 1'b1; bus.b_data = 8'h5A;
      tick();
      chk("s2_sw_busy", bus.busy, 1);
      chk("s2_sw_readies", {bus.a_ready, bus.b_ready}, 0);
      chk("s2_sw_slow", bus.slow, 0);
      tick();
      chk("s2_slow", bus.slow, 1);
      chk("s2_b_ready", bus.b_ready, 1);
      chk("s2_a_ready", bus.a_ready, 0);
      tick();
      bus.b_valid = 1'b0;
      chk("s2_ov", bus.out_valid, 1);
      chk("s2_od", bus.out_data, 8'h5A);
      tick();
      chk("s2_idle", bus.busy, 0);
      chk("s2_slow_hold", bus.slow, 1);

      // 3. burst limit with B waiting (slow=1, both raised: A wins the tie)
      bus.a_valid = 1'b1; bus.a_data = 8'h01;
      bus.b_valid = 1'b1; bus.b_data = 8'hB1;
      tick();
      chk("s3_sw0_readies", {bus.a_ready, bus.b_ready}, 0);
      chk("s3_sw0_slow", bus.slow, 1);
      tick();
      chk("s3_a_slow", bus.slow, 0);
      chk("s3_a_rdy0", bus.a_ready, 1);
      tick(); bus.a_data = 8'h02;
      chk("s3_od1", bus.out_data, 8'h01);
      chk("s3_ov1", bus.out_valid, 1);
      chk("s3_a_rdy1", bus.a_ready, 1);
      tick(); bus.a_data = 8'h03;
      chk("s3_od2", bus.out_data, 8'h02);
      chk("s3_a_rdy2", bus.a_ready, 1);
      tick(); bus.a_data = 8'h04;
      chk("s3_od3", bus.out_data, 8'h03);
      chk("s3_a_rdy_limit", bus.a_ready, 0);
      tick();
      chk("s3_sw1_readies", {bus.a_ready, bus.b_ready}, 0);
      chk("s3_sw1_ov", bus.out_valid, 0);
      chk("s3_sw1_slow", bus.slow, 0);
      tick();
      chk("s3_b_slow", bus.slow, 1);
      chk("s3_b_ready", {bus.a_ready, bus.b_ready}, 2'b01);
      tick(); bus.b_valid = 1'b0;
      chk("s3_b_ov", bus.out_valid, 1);
      chk("s3_b_od", bus.out_data, 8'hB1);
      tick();
      chk("s3_sw2_readies", {bus.a_ready, bus.b_ready}, 0);
      chk("s3_sw2_slow", bus.slow, 1);
      tick();
      chk("s3_resume_slow", bus.slow, 0);
      chk("s3_resume_rdy", bus.a_ready, 1);
      tick(); bus.a_valid = 1'b0;
      chk("s3_resume_ov", bus.out_valid, 1);
      chk("s3_resume_od", bus.out_data, 8'h04);
      tick();
      chk("s3_idle", bus.busy, 0);

      // 4. burst limit with no competitor: bubble after every 3 accepts
      idx = 0; prev_acc = 1'b0; last = 8'h00;
      bus.a_valid = 1'b1; bus.a_data = 8'h21;
      tick();
      for (int c = 0; c < 11; c++) begin
         chk($sformatf("s4_rdy_c%0d", c), bus.a_ready, exp_rdy[c]);
         chk($sformatf("s4_ov_c%0d", c), bus.out_valid, prev_acc);
         if (prev_acc) chk($sformatf("s4_od_c%0d", c), bus.out_data, last);
         chk($sformatf("s4_slow_c%0d", c), bus.slow, 0);
         prev_acc = exp_rdy[c] && bus.a_valid;
         if (prev_acc) begin
            last = bus.a_data;
            idx++;
         end
         tick();
         bus.a_valid = (idx < 8);
         bus.a_data  = 8'h21 + 8'(idx);
      end
      chk("s4_idle", bus.busy, 0);
      chk("s4_ov_end", bus.out_valid, 0);

      // 5. round-robin tie from slow=1: first move ownership to B
      bus.b_valid = 1'b1; bus.b_data = 8'h5B;
      tick(); tick();
      chk("s5_pre_slow", bus.slow, 1);
      tick(); bus.b_valid = 1'b0;
      chk("s5_pre_od", bus.out_data, 8'h5B);
      tick();
      chk("s5_pre_idle", bus.busy, 0);
      bus.a_valid = 1'b1; bus.a_data = 8'h77;
      bus.b_valid = 1'b1; bus.b_data = 8'h88;
      tick();
      chk("s5_sw_readies", {bus.a_ready, bus.b_ready}, 0);
      chk("s5_sw_busy", bus.busy, 1);
      chk("s5_sw_slow", bus.slow, 1);
      tick();
      chk("s5_slow", bus.slow, 0);
      chk("s5_readies", {bus.a_ready, bus.b_ready}, 2'b10);
      tick();
      chk("s5_ov", bus.out_valid, 1);
      chk("s5_od", bus.out_data, 8'h77);

      // 6. async reset mid-burst, no clock edge before checking
      rst_n = 1'b0;
      #1;
      chk("s6_ov", bus.out_valid, 0);
      chk("s6_od", bus.out_data, 0);
      chk("s6_busy", bus.busy, 0);
      chk("s6_slow", bus.slow, 0);
      chk("s6_readies", {bus.a_ready, bus.b_ready}, 0);
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("s6_post_busy", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
